// File: rtl/des_key_scheduler.sv
// des_key_scheduler
//   Sequential DES key schedule engine. Holds a bank of 64-bit keys and, on
//   request, streams the 16 round subkeys of the selected key through PC-2
//   over a valid/ready handshake (K1..K16 to encrypt, K16..K1 to decrypt).
//   Bit numbering follows FIPS 46-3: DES bit 1 is the MSB of every vector.
//
// Ports
//   CLK, RESET         clock, synchronous active-high reset
//   CHIP_SELECT_BAR    active-low enable; high blocks START and aborts a run
//   KEY_WR/_ADDR/_DATA key bank write port (any time, takes effect at the edge)
//   START/ADDRESS/DECRYPT  schedule request, slot and direction
//   ROUND_KEY/ROUND_NUM    current subkey and its number minus one
//   ROUND_KEY_VALID/READY  subkey handshake
//   BUSY, DONE             run in progress / one-cycle completion pulse
//   PARITY_ERROR           scheduled key contains an even-parity byte
module des_key_scheduler #(
    parameter int unsigned NUM_KEYS = 2,
    parameter int unsigned ADDR_W   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CHIP_SELECT_BAR,
    input  logic              KEY_WR,
    input  logic [ADDR_W-1:0] KEY_WR_ADDR,
    input  logic [64:1]       KEY_WR_DATA,
    input  logic              START,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic              DECRYPT,
    output logic [48:1]       ROUND_KEY,
    output logic [4:1]        ROUND_NUM,
    output logic              ROUND_KEY_VALID,
    input  logic              ROUND_KEY_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              PARITY_ERROR
);

    localparam logic [64:1] SLOT1_DEFAULT = 64'h1111001010110001;

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {IDLE, PC1, ROUND, FINISH} state_t;

    state_t      state;
    logic [64:1] key_bank [NUM_KEYS];
    logic [64:1] run_key;
    logic        decrypt_q;
    logic [56:1] cd;
    logic        addr_ok;
    logic        start_ok;

    function automatic logic [56:1] perm_pc1(input logic [64:1] k);
        logic [56:1] r;
        r = '0;
        for (int unsigned j = 0; j < 56; j++) begin
            r[6'(56 - j)] = k[7'(65 - PC1_TBL[j])];
        end
        return r;
    endfunction

    function automatic logic [48:1] perm_pc2(input logic [56:1] v);
        logic [48:1] r;
        r = '0;
        for (int unsigned j = 0; j < 48; j++) begin
            r[6'(48 - j)] = v[6'(57 - PC2_TBL[j])];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 (zero-based 0, 1, 8, 15) shift by one, all others by two.
    function automatic logic double_shift(input logic [4:1] round0);
        return !(round0 == 4'd0 || round0 == 4'd1 || round0 == 4'd8 || round0 == 4'd15);
    endfunction

    // Left rotation moves bits toward DES bit 1, i.e. toward the MSB.
    function automatic logic [56:1] rot_left(input logic [56:1] v, input logic two);
        logic [28:1] c, d;
        c = v[56:29];
        d = v[28:1];
        if (two) return {c[26:1], c[28:27], d[26:1], d[28:27]};
        else     return {c[27:1], c[28], d[27:1], d[28]};
    endfunction

    function automatic logic [56:1] rot_right(input logic [56:1] v, input logic two);
        logic [28:1] c, d;
        c = v[56:29];
        d = v[28:1];
        if (two) return {c[2:1], c[28:3], d[2:1], d[28:3]};
        else     return {c[1], c[28:2], d[1], d[28:2]};
    endfunction

    function automatic logic has_even_byte(input logic [64:1] k);
        logic e;
        e = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            e = e | ~(^k[8*i+1 +: 8]);
        end
        return e;
    endfunction

    assign addr_ok  = 32'(ADDRESS) < NUM_KEYS;
    assign start_ok = START && !CHIP_SELECT_BAR && addr_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                key_bank[i] <= (i == 1) ? SLOT1_DEFAULT : '0;
            end
        end else if (KEY_WR && 32'(KEY_WR_ADDR) < NUM_KEYS) begin
            key_bank[KEY_WR_ADDR] <= KEY_WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            run_key         <= '0;
            decrypt_q       <= 1'b0;
            cd              <= '0;
            ROUND_KEY       <= '0;
            ROUND_NUM       <= '0;
            ROUND_KEY_VALID <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            PARITY_ERROR    <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    // FINISH also accepts a new START so back-to-back runs lose no cycle.
                    DONE <= 1'b0;
                    if (start_ok) begin
                        state        <= PC1;
                        BUSY         <= 1'b1;
                        run_key      <= key_bank[ADDRESS];
                        decrypt_q    <= DECRYPT;
                        PARITY_ERROR <= has_even_byte(key_bank[ADDRESS]);
                    end else begin
                        state <= IDLE;
                    end
                end
                PC1: begin
                    if (CHIP_SELECT_BAR) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        state           <= ROUND;
                        ROUND_KEY_VALID <= 1'b1;
                        if (decrypt_q) begin
                            // C0D0 equals C16D16: the total rotation is 28.
                            cd        <= perm_pc1(run_key);
                            ROUND_KEY <= perm_pc2(perm_pc1(run_key));
                            ROUND_NUM <= 4'd15;
                        end else begin
                            cd        <= rot_left(perm_pc1(run_key), 1'b0);
                            ROUND_KEY <= perm_pc2(rot_left(perm_pc1(run_key), 1'b0));
                            ROUND_NUM <= 4'd0;
                        end
                    end
                end
                ROUND: begin
                    if (CHIP_SELECT_BAR) begin
                        state           <= IDLE;
                        BUSY            <= 1'b0;
                        ROUND_KEY_VALID <= 1'b0;
                    end else if (ROUND_KEY_READY) begin
                        if (ROUND_NUM == (decrypt_q ? 4'd0 : 4'd15)) begin
                            state           <= FINISH;
                            ROUND_KEY_VALID <= 1'b0;
                            BUSY            <= 1'b0;
                            DONE            <= 1'b1;
                        end else if (decrypt_q) begin
                            // Undo the rotation of the round just emitted.
                            cd        <= rot_right(cd, double_shift(ROUND_NUM));
                            ROUND_KEY <= perm_pc2(rot_right(cd, double_shift(ROUND_NUM)));
                            ROUND_NUM <= ROUND_NUM - 4'd1;
                        end else begin
                            cd        <= rot_left(cd, double_shift(ROUND_NUM + 4'd1));
                            ROUND_KEY <= perm_pc2(rot_left(cd, double_shift(ROUND_NUM + 4'd1)));
                            ROUND_NUM <= ROUND_NUM + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler
//   Directed bench for des_key_scheduler (NUM_KEYS=3, ADDR_W=2). A key
//   schedule model computes any subkey Kr directly from the 64-bit key using
//   the cumulative rotation count; a negedge checker compares every valid
//   subkey against it, and FIPS 46-3 literals pin both model and design.
`timescale 1ns/1ps
module tb_des_key_scheduler;

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] SLOT1_KEY = 64'h1111001010110001;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_C = 64'hA1B2C3D4E5F60718;
    localparam logic [47:0] FIPS_K1 = 48'h1B02EFFC7072;
    localparam logic [47:0] FIPS_K2 = 48'h79AED9DBC9E5;
    localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CHIP_SELECT_BAR = 1'b0;
    logic        KEY_WR = 1'b0;
    logic [1:0]  KEY_WR_ADDR = '0;
    logic [63:0] KEY_WR_DATA = '0;
    logic        START = 1'b0;
    logic [1:0]  ADDRESS = '0;
    logic        DECRYPT = 1'b0;
    logic [47:0] ROUND_KEY;
    logic [3:0]  ROUND_NUM;
    logic        ROUND_KEY_VALID;
    logic        ROUND_KEY_READY = 1'b1;
    logic        BUSY;
    logic        DONE;
    logic        PARITY_ERROR;

    int n_cmp = 0;
    int n_bad = 0;

    // Run context published by the stimulus, consumed by the checker.
    logic [63:0] run_key = '0;
    logic        run_dec = 1'b0;

    // Checker state.
    logic [3:0]  exp_num = '0;
    int          acc_cnt = 0;
    int          stall_cnt = 0;
    logic [47:0] last_key = '0;
    logic [3:0]  last_num = '0;
    logic        prev_stall = 1'b0;
    logic [47:0] prev_key = '0;
    logic [3:0]  prev_num = '0;

    des_key_scheduler #(.NUM_KEYS(3), .ADDR_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .CHIP_SELECT_BAR(CHIP_SELECT_BAR),
        .KEY_WR(KEY_WR), .KEY_WR_ADDR(KEY_WR_ADDR), .KEY_WR_DATA(KEY_WR_DATA),
        .START(START), .ADDRESS(ADDRESS), .DECRYPT(DECRYPT),
        .ROUND_KEY(ROUND_KEY), .ROUND_NUM(ROUND_NUM),
        .ROUND_KEY_VALID(ROUND_KEY_VALID), .ROUND_KEY_READY(ROUND_KEY_READY),
        .BUSY(BUSY), .DONE(DONE), .PARITY_ERROR(PARITY_ERROR)
    );

    always #5 CLK = ~CLK;

    // Kr bit j is CD bit PC2[j]; CD bit i of round r is C0/D0 bit (i + shift) mod 28.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int round);
        int sh, p, half, i, src, kbit;
        logic [47:0] res;
        sh = 0;
        res = '0;
        for (int r = 1; r <= round; r++) sh += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
        for (int j = 0; j < 48; j++) begin
            p    = PC2_T[j];
            half = (p <= 28) ? 0 : 28;
            i    = p - half;
            src  = ((i - 1 + sh) % 28) + 1 + half;
            kbit = PC1_T[src - 1];
            res  = {res[46:0], key[6'(64 - kbit)]};
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (DONE && BUSY) chk("done_busy_overlap", 1, 0);
            if (BUSY && !ROUND_KEY_VALID) begin
                exp_num   = run_dec ? 4'd15 : 4'd0;
                acc_cnt   = 0;
                stall_cnt = 0;
            end
            if (ROUND_KEY_VALID) begin
                chk("round_num", 64'(ROUND_NUM), 64'(exp_num));
                chk("round_key", 64'(ROUND_KEY), 64'(model_subkey(run_key, int'(ROUND_NUM) + 1)));
                if (prev_stall) begin
                    chk("stall_key", 64'(ROUND_KEY), 64'(prev_key));
                    chk("stall_num", 64'(ROUND_NUM), 64'(prev_num));
                end
                if (ROUND_KEY_READY) begin
                    last_key = ROUND_KEY;
                    last_num = ROUND_NUM;
                    acc_cnt++;
                    exp_num = run_dec ? exp_num - 4'd1 : exp_num + 4'd1;
                end else begin
                    stall_cnt++;
                end
            end else if (prev_stall) begin
                chk("valid_dropped_in_stall", 0, 1);
            end
            prev_stall = ROUND_KEY_VALID && !ROUND_KEY_READY;
            prev_key   = ROUND_KEY;
            prev_num   = ROUND_NUM;
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1 RESET = 1'b0;
    endtask

    task automatic write_key(input logic [1:0] addr, input logic [63:0] data);
        @(posedge CLK); #1 KEY_WR = 1'b1; KEY_WR_ADDR = addr; KEY_WR_DATA = data;
        @(posedge CLK); #1 KEY_WR = 1'b0;
    endtask

    // Returns #1 after the START edge t.
    task automatic do_start(input logic [1:0] addr, input logic dec);
        @(posedge CLK); #1 START = 1'b1; ADDRESS = addr; DECRYPT = dec;
        @(posedge CLK); #1 START = 1'b0;
    endtask

    task automatic wait_done(input logic rnd);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge CLK); #1;
            if (DONE) seen = 1'b1;
            else if (rnd) ROUND_KEY_READY = 1'($urandom_range(0, 1));
        end
        ROUND_KEY_READY = 1'b1;
        chk("done_seen", 64'(seen), 1);
    endtask

    task automatic wait_round(input logic [3:0] rn);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge CLK); #1;
            if (ROUND_KEY_VALID && ROUND_NUM == rn) seen = 1'b1;
        end
        chk("round_reached", 64'(seen), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key"}, 64'(ROUND_KEY), 0);
        chk({tag, "_num"}, 64'(ROUND_NUM), 0);
        chk({tag, "_valid"}, 64'(ROUND_KEY_VALID), 0);
        chk({tag, "_busy"}, 64'(BUSY), 0);
        chk({tag, "_done"}, 64'(DONE), 0);
        chk({tag, "_parity"}, 64'(PARITY_ERROR), 0);
    endtask

    initial begin
        logic done_any;

        // Pin the model to FIPS 46-3 worked example.
        chk("model_k1", 64'(model_subkey(FIPS_KEY, 1)), 64'(FIPS_K1));
        chk("model_k2", 64'(model_subkey(FIPS_KEY, 2)), 64'(FIPS_K2));
        chk("model_k16", 64'(model_subkey(FIPS_KEY, 16)), 64'(FIPS_K16));

        repeat (2) @(posedge CLK);
        #1 chk_all_zero("reset");
        RESET = 1'b0;

        // Encrypt with exact timing.
        write_key(2'd0, FIPS_KEY);
        run_key = FIPS_KEY; run_dec = 1'b0;
        do_start(2'd0, 1'b0);
        chk("enc_busy_t1", 64'(BUSY), 1);
        chk("enc_valid_t1", 64'(ROUND_KEY_VALID), 0);
        @(posedge CLK); #1;
        chk("enc_k1", 64'(ROUND_KEY), 64'(FIPS_K1));
        chk("enc_k1_num", 64'(ROUND_NUM), 0);
        chk("enc_k1_valid", 64'(ROUND_KEY_VALID), 1);
        repeat (15) @(posedge CLK);
        #1;
        chk("enc_k16", 64'(ROUND_KEY), 64'(FIPS_K16));
        chk("enc_k16_num", 64'(ROUND_NUM), 15);
        @(posedge CLK); #1;
        chk("enc_done_t18", 64'(DONE), 1);
        chk("enc_busy_t18", 64'(BUSY), 0);
        chk("enc_valid_t18", 64'(ROUND_KEY_VALID), 0);
        @(posedge CLK); #1;
        chk("enc_done_pulse", 64'(DONE), 0);
        chk("enc_count", 64'(acc_cnt), 16);
        chk("enc_parity", 64'(PARITY_ERROR), 0);

        // Decrypt.
        run_dec = 1'b1;
        do_start(2'd0, 1'b1);
        @(posedge CLK); #1;
        chk("dec_first", 64'(ROUND_KEY), 64'(FIPS_K16));
        chk("dec_first_num", 64'(ROUND_NUM), 15);
        wait_done(1'b0);
        chk("dec_last", 64'(last_key), 64'(FIPS_K1));
        chk("dec_last_num", 64'(last_num), 0);
        chk("dec_count", 64'(acc_cnt), 16);

        // Backpressure.
        run_dec = 1'b0;
        do_start(2'd0, 1'b0);
        wait_done(1'b1);
        chk("bp_count", 64'(acc_cnt), 16);
        chk("bp_last", 64'(last_key), 64'(FIPS_K16));
        chk("bp_stalls_seen", 64'(stall_cnt != 0), 1);

        // Reset defaults: slot 1 has even-parity bytes.
        do_reset();
        run_key = SLOT1_KEY; run_dec = 1'b0;
        do_start(2'd1, 1'b0);
        wait_done(1'b0);
        chk("slot1_count", 64'(acc_cnt), 16);
        chk("slot1_parity", 64'(PARITY_ERROR), 1);

        // Out-of-range slot is ignored.
        do_start(2'd3, 1'b0);
        chk("badaddr_busy_t1", 64'(BUSY), 0);
        @(posedge CLK); #1;
        chk("badaddr_busy_t2", 64'(BUSY), 0);
        chk("badaddr_valid_t2", 64'(ROUND_KEY_VALID), 0);

        // Abort at round 5 (slot 0 back to its all-zero default).
        run_key = '0;
        do_start(2'd0, 1'b0);
        wait_round(4'd5);
        CHIP_SELECT_BAR = 1'b1;
        @(posedge CLK); #1;
        chk("abort_valid", 64'(ROUND_KEY_VALID), 0);
        chk("abort_busy", 64'(BUSY), 0);
        CHIP_SELECT_BAR = 1'b0;
        done_any = DONE;
        repeat (20) begin
            @(posedge CLK); #1;
            done_any = done_any | DONE;
        end
        chk("abort_no_done", 64'(done_any), 0);

        // Reset at round 9, then slot 0 must be back to zero.
        write_key(2'd0, FIPS_KEY);
        run_key = FIPS_KEY;
        do_start(2'd0, 1'b0);
        wait_round(4'd9);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk_all_zero("midreset");
        RESET = 1'b0;
        run_key = '0;
        do_start(2'd0, 1'b0);
        @(posedge CLK); #1;
        chk("zero_slot_k1", 64'(ROUND_KEY), 0);
        chk("zero_slot_valid", 64'(ROUND_KEY_VALID), 1);
        wait_done(1'b0);
        chk("zero_slot_parity", 64'(PARITY_ERROR), 1);

        // Write collision: same-cycle and mid-run writes do not affect this run.
        write_key(2'd0, FIPS_KEY);
        run_key = FIPS_KEY;
        @(posedge CLK); #1;
        START = 1'b1; ADDRESS = 2'd0; DECRYPT = 1'b0;
        KEY_WR = 1'b1; KEY_WR_ADDR = 2'd0; KEY_WR_DATA = KEY_B;
        @(posedge CLK); #1;
        START = 1'b0; KEY_WR = 1'b0;
        repeat (3) @(posedge CLK);
        write_key(2'd0, KEY_C);
        wait_done(1'b0);
        chk("coll_count", 64'(acc_cnt), 16);
        chk("coll_last", 64'(last_key), 64'(FIPS_K16));
        run_key = KEY_C;
        do_start(2'd0, 1'b0);
        wait_done(1'b0);
        chk("newkey_count", 64'(acc_cnt), 16);
        chk("newkey_last", 64'(last_key), 64'(model_subkey(KEY_C, 16)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
